// File: rtl/image_writer_master_if.sv
// Bus bundle between the pixel source, image_writer_master and the AXI4-Lite slave.
// Carries the AXI4-Stream pixel sink (pix_*) and the AXI4-Lite write channels
// (m_axi_aw*, m_axi_w*, m_axi_b*).
//   master modport : the writer's view (drives pix_tready and the AXI master side)
//   slave  modport : the environment's view (drives the pixel stream and AXI slave side)
interface image_writer_master_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [31:0]           pix_tdata;
  logic                  pix_tvalid;
  logic                  pix_tready;

  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [31:0]           m_axi_wdata;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    input  pix_tdata, pix_tvalid,
    output pix_tready,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output pix_tdata, pix_tvalid,
    input  pix_tready,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/image_writer_master.sv
// AXI4-Lite write initiator feeding the image loader. Each pixel word accepted
// on the stream sink becomes one single-beat write to BASE_ADDR + index*ADDR_STRIDE.
// After the NUM_WORDS-th write response, start pulses for one cycle.
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, synchronous active-low reset
//   bus                       : pixel stream sink + AXI4-Lite write master
//   start                     : one-cycle pulse after the last response of an image
//   busy                      : state not IDLE, or a partial image in progress
//   done                      : set with start, cleared by the next accepted word
//   err_count                 : saturating count of non-OKAY write responses
//
// state | meaning
// IDLE  | pix_tready high, waiting for a pixel word
// ISSUE | AW and W valid, each dropped on its own handshake
// RESP  | both handshakes done, waiting for the write response
// START | one-cycle start pulse, then back to IDLE
module image_writer_master #(
  parameter int unsigned NUM_WORDS   = 784,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  image_writer_master_if.master        bus,
  output logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  err_count
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, START} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic                  pix_tready_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;

  assign bus.pix_tready    = pix_tready_q;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = 4'b1111;
  assign bus.m_axi_wvalid  = wvalid_q;
  assign bus.m_axi_bready  = bready_q;

  assign busy = (state != IDLE) || (idx != '0);

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state        <= IDLE;
      idx          <= '0;
      pix_tready_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      awaddr_q     <= BASE_A;
      wdata_q      <= '0;
      start        <= 1'b0;
      done         <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pix_tready_q && bus.pix_tvalid) begin
            wdata_q      <= bus.pix_tdata;
            awvalid_q    <= 1'b1;
            wvalid_q     <= 1'b1;
            bready_q     <= 1'b1;
            pix_tready_q <= 1'b0;
            done         <= 1'b0;
            state        <= ISSUE;
          end else begin
            // covers the first cycle after reset, when tready is still low
            pix_tready_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (awvalid_q && bus.m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.m_axi_wready) wvalid_q <= 1'b0;
          // a channel is finished if it already dropped or handshakes now
          if ((!awvalid_q || bus.m_axi_awready) && (!wvalid_q || bus.m_axi_wready))
            state <= RESP;
        end
        RESP: begin
          if (bus.m_axi_bvalid) begin
            bready_q <= 1'b0;
            if (bus.m_axi_bresp != 2'b00 && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            if (idx == LAST_IDX) begin
              idx      <= '0;
              awaddr_q <= BASE_A;
              start    <= 1'b1;
              done     <= 1'b1;
              state    <= START;
            end else begin
              idx          <= idx + IDX_ONE;
              awaddr_q     <= awaddr_q + STRIDE_A;
              pix_tready_q <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        START: begin
          start        <= 1'b0;
          pix_tready_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_writer_master.sv
module tb_image_writer_master;
  localparam int NW     = 784;
  localparam int AW     = 12;
  localparam int BASE   = 0;
  localparam int STRIDE = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] err_count;

  image_writer_master_if #(.ADDR_WIDTH(AW)) ifc ();

  image_writer_master #(.NUM_WORDS(NW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .bus          (ifc),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  // test configuration (main)
  int aw_hold = 1, w_hold = 1, b_delay = 0, err_a = -1, err_b = -1;
  bit chk_rate = 0, chk_skew = 0;
  int drv_idx = 0;
  bit stuck = 0;

  // monitor outputs
  bit aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, mon_rst = 0;
  int n_start = 0, img_b = 0;

  // slave-side count of injected errors since reset
  int exp_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI4-Lite slave model ----------------
  int aw_cnt, w_cnt, b_wait, s_widx;
  bit aw_got, w_got;
  initial begin
    ifc.m_axi_awready = 0; ifc.m_axi_wready = 0; ifc.m_axi_bvalid = 0; ifc.m_axi_bresp = 0;
    aw_cnt = 0; w_cnt = 0; b_wait = 0; s_widx = 0; aw_got = 0; w_got = 0;
    forever begin
      @(posedge clk); #1;
      if (!mon_rst) begin
        ifc.m_axi_awready = 0; ifc.m_axi_wready = 0; ifc.m_axi_bvalid = 0; ifc.m_axi_bresp = 0;
        aw_cnt = 0; w_cnt = 0; b_wait = 0; s_widx = 0; aw_got = 0; w_got = 0; exp_err = 0;
      end else begin
        if (aw_hs_n) begin aw_cnt = 0; aw_got = 1; end
        if (w_hs_n) begin w_cnt = 0; w_got = 1; end
        if (b_hs_n) begin
          ifc.m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0;
          s_widx = (s_widx + 1) % NW;
        end
        ifc.m_axi_awready = ifc.m_axi_awvalid && (aw_cnt >= aw_hold - 1);
        if (ifc.m_axi_awvalid && !ifc.m_axi_awready) aw_cnt++;
        ifc.m_axi_wready = ifc.m_axi_wvalid && (w_cnt >= w_hold - 1);
        if (ifc.m_axi_wvalid && !ifc.m_axi_wready) w_cnt++;
        if (aw_got && w_got && !ifc.m_axi_bvalid) begin
          if (b_wait >= b_delay) begin
            ifc.m_axi_bvalid = 1;
            if (s_widx == err_a || s_widx == err_b) begin
              ifc.m_axi_bresp = 2'b10; exp_err++;
            end else ifc.m_axi_bresp = 2'b00;
          end else b_wait++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [AW-1:0] aw_qa[$];
  logic [31:0]   w_qd[$];
  int  cyc = 0, last_acc = 0, aw_len = 0, w_len = 0;
  bit  last_acc_ok = 0, start_next = 0, done_m = 0, in_flight = 0, prev_rst = 0;
  bit  aw_wait_p = 0, w_wait_p = 0;
  logic [AW-1:0] aw_prev;
  logic [31:0]   w_prev;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_rst = 0; prev_rst = 1;
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
        exp_q.delete(); aw_qa.delete(); w_qd.delete();
        img_b = 0; start_next = 0; done_m = 0; in_flight = 0; last_acc_ok = 0;
        aw_len = 0; w_len = 0; aw_wait_p = 0; w_wait_p = 0;
      end else begin
        bit exp_start, acc, aw_hs, w_hs, b_hs;
        mon_rst = 1;
        if (prev_rst) begin
          chk("rst_pix_tready", ifc.pix_tready, 0);
          chk("rst_awvalid", ifc.m_axi_awvalid, 0);
          chk("rst_wvalid", ifc.m_axi_wvalid, 0);
          chk("rst_bready", ifc.m_axi_bready, 0);
          chk("rst_awaddr", ifc.m_axi_awaddr, BASE);
          chk("rst_wdata", ifc.m_axi_wdata, 0);
          chk("rst_err_count", err_count, 0);
        end
        prev_rst = 0;
        exp_start = start_next; start_next = 0;
        acc  = ifc.pix_tvalid && ifc.pix_tready;
        aw_hs = ifc.m_axi_awvalid && ifc.m_axi_awready;
        w_hs  = ifc.m_axi_wvalid && ifc.m_axi_wready;
        b_hs  = ifc.m_axi_bvalid && ifc.m_axi_bready;

        chk("start", start, exp_start);
        if (exp_start) begin done_m = 1; n_start++; end
        chk("done", done, done_m);
        chk("busy", busy, in_flight || exp_start || img_b != 0);
        chk("tready_outside_idle", ifc.pix_tready &&
            (ifc.m_axi_awvalid || ifc.m_axi_wvalid || ifc.m_axi_bready || start), 0);

        if (aw_wait_p) begin
          chk("awvalid_held", ifc.m_axi_awvalid, 1);
          chk("awaddr_stable", ifc.m_axi_awaddr, aw_prev);
        end
        if (w_wait_p) begin
          chk("wvalid_held", ifc.m_axi_wvalid, 1);
          chk("wdata_stable", ifc.m_axi_wdata, w_prev);
        end
        aw_wait_p = ifc.m_axi_awvalid && !ifc.m_axi_awready; aw_prev = ifc.m_axi_awaddr;
        w_wait_p  = ifc.m_axi_wvalid && !ifc.m_axi_wready;   w_prev  = ifc.m_axi_wdata;

        if (ifc.m_axi_awvalid) aw_len++;
        if (ifc.m_axi_wvalid) w_len++;
        if (aw_hs) begin
          if (chk_skew) chk("aw_hold_cycles", aw_len, 3);
          aw_len = 0;
          chk("awprot", ifc.m_axi_awprot, 0);
          aw_qa.push_back(ifc.m_axi_awaddr);
        end
        if (w_hs) begin
          if (chk_skew) chk("w_hold_cycles", w_len, 1);
          w_len = 0;
          chk("wstrb", ifc.m_axi_wstrb, 4'hF);
          w_qd.push_back(ifc.m_axi_wdata);
        end
        while (aw_qa.size() > 0 && w_qd.size() > 0) begin
          logic [AW-1:0] a;
          logic [31:0]   d;
          a = aw_qa.pop_front(); d = w_qd.pop_front();
          if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("write_addr", a, e.a);
            chk("write_data", d, e.d);
          end
        end
        if (b_hs) begin
          in_flight = 0;
          img_b++;
          if (img_b == NW) begin img_b = 0; start_next = 1; end
        end
        if (acc) begin
          if (chk_rate && last_acc_ok) chk("cycles_per_word", cyc - last_acc, 3);
          last_acc = cyc; last_acc_ok = 1;
          in_flight = 1; done_m = 0;
        end
        aw_hs_n = aw_hs; w_hs_n = w_hs; b_hs_n = b_hs;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_word(input logic [31:0] d);
    bit hs = 0;
    int g = 0;
    if (stuck) return;
    ifc.pix_tvalid = 1; ifc.pix_tdata = d;
    do begin
      @(negedge clk); hs = ifc.pix_tvalid && ifc.pix_tready;
      @(posedge clk); #1; g++;
    end while (!hs && g < 2000);
    if (!hs) begin
      chk("accept_timeout", 0, 1);
      stuck = 1;
    end else begin
      wr_t e;
      e.a = AW'(BASE + drv_idx * STRIDE);
      e.d = d;
      exp_q.push_back(e);
      drv_idx = (drv_idx + 1) % NW;
    end
  endtask

  task automatic send_words(input int n, input bit rnd, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (gap > 0) begin
        ifc.pix_tvalid = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      push_word(rnd ? $urandom : 32'(i));
    end
    ifc.pix_tvalid = 0;
  endtask

  task automatic wait_starts(input int target, input string name);
    int g = 0;
    while (n_start < target && g < 2000) begin @(posedge clk); #1; g++; end
    repeat (4) begin @(posedge clk); #1; end
    chk({name, "_starts"}, n_start, target);
    chk({name, "_err_count"}, err_count, exp_err);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_awaddr_base"}, ifc.m_axi_awaddr, BASE);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1;
    drv_idx = 0;
  endtask

  initial begin
    rst_n = 0; ifc.pix_tvalid = 0; ifc.pix_tdata = 0;
    @(posedge clk); #1;
    do_reset(3);

    // zero-wait slave, data = index, source always valid
    chk_rate = 1;
    send_words(NW, 0, 0);
    wait_starts(1, "zero_wait");
    chk_rate = 0;

    // awready delayed, wready immediate
    aw_hold = 3; chk_skew = 1;
    send_words(NW, 1, 0);
    wait_starts(2, "skew");
    aw_hold = 1; chk_skew = 0;

    // SLVERR on words 5 and 700
    err_a = 5; err_b = 700;
    send_words(NW, 1, 0);
    wait_starts(3, "slverr");
    chk("slverr_total", err_count, 2);
    err_a = -1; err_b = -1;

    // reset after word 400's response, then a full image
    send_words(401, 1, 0);
    begin
      int g = 0;
      while (img_b != 401 && g < 2000) begin @(posedge clk); #1; g++; end
    end
    chk("partial_responses", img_b, 401);
    chk("no_start_before_reset", n_start, 3);
    do_reset(2);
    send_words(NW, 1, 0);
    wait_starts(4, "after_reset");

    // source stalls and slow responses
    b_delay = 10;
    send_words(NW, 1, 50);
    wait_starts(5, "stall");
    b_delay = 0;

    // two back-to-back images
    send_words(2 * NW, 1, 0);
    wait_starts(7, "back_to_back");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_writer_master.md
# image_writer_master

AXI4-Lite write initiator that feeds `image_loader_module`. It accepts pixel words on an AXI4-Stream sink and issues one single-beat AXI4-Lite write per word to consecutive addresses, starting at `BASE_ADDR` with a stride of `ADDR_STRIDE`. After the `NUM_WORDS`-th write response it pulses `start` for one cycle, which launches the loader's inference stream. It sits between the pixel source (DMA/UART bridge) and the loader's `s_axi` port.

## Interface
- `NUM_WORDS`, 784: words per image.
- `ADDR_WIDTH`, 12: AXI address width.
- `BASE_ADDR`, 0: address of word 0.
- `ADDR_STRIDE`, 4: byte increment per word.
- `s_axi_aclk` in 1: single clock, rising edge.
- `s_axi_aresetn` in 1: synchronous, active-low reset.
- `pix_tdata` in 32: pixel word.
- `pix_tvalid` in 1: source word valid.
- `pix_tready` out 1: block accepts a word.
- `m_axi_awaddr` out ADDR_WIDTH: write address.
- `m_axi_awprot` out 3: constant 3'b000.
- `m_axi_awvalid` out 1 / `m_axi_awready` in 1: AW handshake.
- `m_axi_wdata` out 32: write data.
- `m_axi_wstrb` out 4: constant 4'b1111.
- `m_axi_wvalid` out 1 / `m_axi_wready` in 1: W handshake.
- `m_axi_bresp` in 2: write response.
- `m_axi_bvalid` in 1 / `m_axi_bready` out 1: B handshake.
- `start` out 1: one-cycle pulse after the last response of an image.
- `busy` out 1: high whenever the state is not IDLE, or the word index is nonzero.
- `done` out 1: set with `start`; cleared on the next accepted word.
- `err_count` out 16: count of non-OKAY `bresp` values; saturates at 16'hFFFF.

## Operation
- States: IDLE, ISSUE, RESP, START.
- IDLE:
  - `pix_tready`=1.
  - When `pix_tvalid` is high, latch `pix_tdata` into `m_axi_wdata` and go to ISSUE.
- ISSUE:
  - `m_axi_awvalid` and `m_axi_wvalid` rise together. Each drops independently on its own handshake (valid&&ready).
  - `m_axi_bready`=1 from ISSUE entry until the B handshake.
  - Go to RESP once both handshakes have completed. This includes completing both in the same cycle.
- RESP: wait for `m_axi_bvalid`. On the B handshake:
  - If `bresp`!=2'b00, increment `err_count` (saturating).
  - If index==NUM_WORDS-1: clear the index, reset `awaddr` to `BASE_ADDR`, and go to START.
  - Otherwise: increment the index, add `ADDR_STRIDE` to `awaddr`, and go to IDLE.
- START: `start`=1 for exactly one cycle, `done` is set, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap-around permitted; default range 0x000–0xC3C).
- The data and address values stay stable while the corresponding valid signal is high (AXI rule). No valid signal depends combinationally on a ready signal.
- A `bvalid` arriving before both AW and W handshakes is ignored. The slave must not do this.
- Errors do not abort the image. Writing continues and `start` still fires.
- `err_count` clears only on reset.

## Timing
- Reset values:
  - `pix_tready`, `m_axi_awvalid`, `m_axi_wvalid`, `m_axi_bready`, `start`, `done`, `busy` = 0.
  - `m_axi_awaddr` = BASE_ADDR; `m_axi_wdata` = 0; `err_count` = 0; state = IDLE; index = 0.
  - `pix_tready` rises the first cycle after reset deasserts.
- Per-word minimum with zero-wait slave:
  - Accept at cycle T.
  - awvalid/wvalid high at T+1; handshakes at T+1.
  - bvalid at T+2; B handshake at T+2.
  - `pix_tready` high again at T+3.
- `start` is high in the cycle after the last B handshake.
- Reset mid-image: on the next edge all outputs return to reset values and in-flight valid signals drop. The partial image is discarded and no `start` is issued.
- `pix_tready` is 0 in every state except IDLE. The source may hold `pix_tvalid` high indefinitely.

## Test plan
- **Zero-wait slave, 784 words (data = i):**
  - Writes to 0x000, 0x004, …, 0xC3C with `wdata`=i.
  - `start` goes high for 1 cycle, 1 cycle after the 784th B handshake.
  - `err_count`=0; 3 cycles per word.
- **Skewed slave (`awready` delayed 3 cycles, `wready` immediate):**
  - `wvalid` drops after 1 cycle; `awvalid` holds 3 cycles with a stable address.
  - Exactly one write per word.
- **Slave returns SLVERR (2'b10) on words 5 and 700:**
  - `err_count`=2 at the end; `start` still pulses.
- **Reset asserted after word 400's B handshake, then a full 784-word image:**
  - No `start` before the reset.
  - The new image starts at 0x000.
  - `start` pulses once, after the second image's last word.
- **Source stalls (random `pix_tvalid` gaps 0–50 cycles) and `bvalid` delayed 10 cycles:**
  - No duplicated or dropped words; `pix_tready` is never high outside IDLE.
- **Two back-to-back images:**
  - The second image's word 0 goes to 0x000.
  - `done` clears on its first accept.
  - `start` pulses twice in total.
